// File: rtl/ifetch_unit.sv
// Instruction fetcher: PC, direct-mapped icache with whole-line refill, and next-PC prediction.
// Optional IFETCH_BHT_EN adds a 2-bit-counter branch history table for conditional branches.
module ifetch_unit #(
  parameter int unsigned ICACHE_LINES = 16,
  parameter int unsigned LINE_WORDS   = 4,
  parameter int unsigned BHT_SIZE     = 64,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     rollback,
  input  logic [31:0]              rollback_pc,
  input  logic                     stall,
  output logic                     if_inst_rdy,
  output logic [31:0]              if_inst,
  output logic [31:0]              if_inst_pc,
  output logic                     if_inst_pred_jump,
  output logic                     mc_en,
  output logic [31:0]              mc_addr,
  input  logic                     mc_done,
  input  logic [32*LINE_WORDS-1:0] mc_data,
  input  logic                     br_update,
  input  logic [31:0]              br_pc,
  input  logic                     br_taken
);

  localparam int unsigned OFF  = $clog2(LINE_WORDS) + 2;
  localparam int unsigned IDXW = $clog2(ICACHE_LINES);
  localparam int unsigned TAGW = 32 - OFF - IDXW;
  localparam int unsigned WSW  = OFF - 2;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inst_rdy_q, inst_rdy_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        pred_q, pred_d;
  logic        mc_en_q, mc_en_d;
  logic [31:0] mc_addr_q, mc_addr_d;

  logic [ICACHE_LINES-1:0]      valid_q;
  logic [TAGW-1:0]              tag_q  [ICACHE_LINES];
  logic [LINE_WORDS-1:0][31:0]  line_q [ICACHE_LINES];

  logic [IDXW-1:0] idx_c, fill_idx_c;
  logic [TAGW-1:0] tag_c, fill_tag_c;
  logic [WSW-1:0]  wsel_c;
  logic            hit_c, fill_c;
  logic [31:0]     word_c, jimm_c, bimm_c, next_pc_c;
  logic            pred_taken_c, pred_jump_c;
  logic            unused_c;

  assign if_inst_rdy       = inst_rdy_q;
  assign if_inst           = inst_q;
  assign if_inst_pc        = inst_pc_q;
  assign if_inst_pred_jump = pred_q;
  assign mc_en             = mc_en_q;
  assign mc_addr           = mc_addr_q;

  // Lookup on the current PC; fills always target the latched refill address.
  assign idx_c      = pc_q[OFF +: IDXW];
  assign tag_c      = pc_q[31 -: TAGW];
  assign wsel_c     = pc_q[OFF-1:2];
  assign hit_c      = valid_q[idx_c] && (tag_q[idx_c] == tag_c);
  assign word_c     = line_q[idx_c][wsel_c];
  assign fill_idx_c = mc_addr_q[OFF +: IDXW];
  assign fill_tag_c = mc_addr_q[31 -: TAGW];
  assign fill_c     = (state_q == S_WAIT) && mc_done;

  assign jimm_c = {{12{word_c[31]}}, word_c[19:12], word_c[20], word_c[30:21], 1'b0};
  assign bimm_c = {{20{word_c[31]}}, word_c[7], word_c[30:25], word_c[11:8], 1'b0};

`ifdef IFETCH_BHT_EN
  localparam int unsigned BHTW = $clog2(BHT_SIZE);

  logic [1:0]      bht_q [BHT_SIZE];
  logic [BHTW-1:0] bht_upd_idx_c;

  assign bht_upd_idx_c = br_pc[BHTW+1:2];
  assign pred_taken_c  = bht_q[pc_q[BHTW+1:2]][1];
  assign unused_c      = ^{br_pc, pc_q[1:0], mc_addr_q[OFF-1:0]};

  // Saturating counters; a same-cycle lookup sees the pre-update value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < BHT_SIZE; i++) begin
        bht_q[BHTW'(i)] <= 2'b01;
      end
    end else if (rdy && br_update) begin
      if (br_taken && (bht_q[bht_upd_idx_c] != 2'b11)) begin
        bht_q[bht_upd_idx_c] <= bht_q[bht_upd_idx_c] + 2'b01;
      end else if (!br_taken && (bht_q[bht_upd_idx_c] != 2'b00)) begin
        bht_q[bht_upd_idx_c] <= bht_q[bht_upd_idx_c] - 2'b01;
      end
    end
  end
`else
  assign pred_taken_c = 1'b0;
  assign unused_c     = ^{br_update, br_taken, br_pc, pc_q[1:0], mc_addr_q[OFF-1:0], 32'(BHT_SIZE)};
`endif

  // Next-PC prediction: JAL always taken, branches per predictor, JALR never.
  always_comb begin
    next_pc_c   = pc_q + 32'd4;
    pred_jump_c = 1'b0;
    if (word_c[6:0] == OP_JAL) begin
      next_pc_c   = pc_q + jimm_c;
      pred_jump_c = 1'b1;
    end else if ((word_c[6:0] == OP_BRANCH) && pred_taken_c) begin
      next_pc_c   = pc_q + bimm_c;
      pred_jump_c = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_rdy_d = 1'b0;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    pred_d     = pred_q;
    mc_en_d    = mc_en_q;
    mc_addr_d  = mc_addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (rollback) begin
          pc_d = rollback_pc;
        end else if (!hit_c) begin
          mc_en_d   = 1'b1;
          mc_addr_d = {pc_q[31:OFF], {OFF{1'b0}}};
          state_d   = S_WAIT;
        end else if (!stall) begin
          inst_rdy_d = 1'b1;
          inst_d     = word_c;
          inst_pc_d  = pc_q;
          pred_d     = pred_jump_c;
          pc_d       = next_pc_c;
        end
      end
      S_WAIT: begin
        // A rollback only redirects the PC; the outstanding fill always completes.
        if (rollback) begin
          pc_d = rollback_pc;
        end
        if (mc_done) begin
          mc_en_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      inst_rdy_q <= 1'b0;
      inst_q     <= 32'h0;
      inst_pc_q  <= 32'h0;
      pred_q     <= 1'b0;
      mc_en_q    <= 1'b0;
      mc_addr_q  <= 32'h0;
      valid_q    <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_rdy_q <= inst_rdy_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      pred_q     <= pred_d;
      mc_en_q    <= mc_en_d;
      mc_addr_q  <= mc_addr_d;
      if (fill_c) begin
        valid_q[fill_idx_c] <= 1'b1;
      end
    end
  end

  // Tag and data arrays need no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (rdy && fill_c) begin
      tag_q[fill_idx_c]  <= fill_tag_c;
      line_q[fill_idx_c] <= mc_data;
    end
  end

endmodule
